// File: rtl/block_move_ctrl.sv
// block_move_ctrl: frame-synchronous motion scheduler for the moving block.
// Optional build macro: BLOCK_COLOR_CYCLE_EN steps the block colour through an
// 8-entry table on every commit that contains a bounce. When the macro is not
// defined, block_color is the constant BLOCK_COLOR.
module block_move_ctrl #(
  parameter int          H_DISP      = 1280,
  parameter int          V_DISP      = 720,
  parameter int          BLOCK_SIZE  = 40,
  parameter int          STEP        = 1,
  parameter int          FRAME_DIV   = 1,
  parameter logic [23:0] BLOCK_COLOR = 24'h0000FF
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        video_vs,
  input  logic        run,
  output logic [10:0] block_x,
  output logic [10:0] block_y,
  output logic        block_upd,
  output logic        dir_x,
  output logic        dir_y,
  output logic [7:0]  bounce_cnt,
  output logic [23:0] block_color
);

  localparam logic [10:0] XMAX   = 11'(H_DISP - BLOCK_SIZE);
  localparam logic [10:0] YMAX   = 11'(V_DISP - BLOCK_SIZE);
  localparam logic [11:0] STEP12 = 12'(STEP);
  localparam int          DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT, CALC, COMMIT} state_t;

  state_t           state, state_nxt;
  logic             vs_d;
  logic             frame_evt;
  logic [DIV_W-1:0] div;
  logic [11:0]      x_sum, y_sum;
  logic [10:0]      nx, ny;
  logic             ndir_x, ndir_y;
  logic             flip;

  assign frame_evt = video_vs & ~vs_d;

  // Delay the frame sync by one cycle so a rising edge can be detected
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) vs_d <= 1'b0;
    else            vs_d <= video_vs;
  end

  // FSM state register
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic: IDLE only aligns to a frame, WAIT divides frames down
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_evt) state_nxt = WAIT;
      WAIT:    if (frame_evt && run && (div == DIV_LAST)) state_nxt = CALC;
      CALC:    state_nxt = COMMIT;
      COMMIT:  state_nxt = WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame divider counts only frames seen in WAIT while running
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div <= '0;
    end else if ((state == WAIT) && frame_evt && run) begin
      div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

  // Next position and direction with edge reflection; 12-bit sums cannot overflow
  always_comb begin
    x_sum  = {1'b0, block_x} + STEP12;
    y_sum  = {1'b0, block_y} + STEP12;
    nx     = block_x;
    ny     = block_y;
    ndir_x = dir_x;
    ndir_y = dir_y;
    if (dir_x) begin
      if (x_sum >= {1'b0, XMAX}) begin nx = XMAX; ndir_x = 1'b0; end
      else                             nx = x_sum[10:0];
    end else begin
      if ({1'b0, block_x} <= STEP12) begin nx = '0; ndir_x = 1'b1; end
      else                                 nx = block_x - STEP12[10:0];
    end
    if (dir_y) begin
      if (y_sum >= {1'b0, YMAX}) begin ny = YMAX; ndir_y = 1'b0; end
      else                             ny = y_sum[10:0];
    end else begin
      if ({1'b0, block_y} <= STEP12) begin ny = '0; ndir_y = 1'b1; end
      else                                 ny = block_y - STEP12[10:0];
    end
    flip = (ndir_x != dir_x) | (ndir_y != dir_y);
  end

  // Publish the computed position as one atomic update, visible during COMMIT
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      block_x    <= '0;
      block_y    <= '0;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      block_upd  <= 1'b0;
      bounce_cnt <= '0;
    end else begin
      block_upd <= (state == CALC);
      if (state == CALC) begin
        block_x <= nx;
        block_y <= ny;
        dir_x   <= ndir_x;
        dir_y   <= ndir_y;
        if (flip) bounce_cnt <= bounce_cnt + 8'd1;
      end
    end
  end

`ifdef BLOCK_COLOR_CYCLE_EN
  logic [2:0] color_idx;

  function automatic logic [23:0] color_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFF0000;
      3'd1:    return 24'h00FF00;
      3'd2:    return 24'h0000FF;
      3'd3:    return 24'hFFFF00;
      3'd4:    return 24'h00FFFF;
      3'd5:    return 24'hFF00FF;
      3'd6:    return 24'hFFFFFF;
      default: return 24'h808080;
    endcase
  endfunction

  // Step the colour together with the bounce counter so both change in COMMIT
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      color_idx   <= 3'd0;
      block_color <= color_lut(3'd0);
    end else if ((state == CALC) && flip) begin
      color_idx   <= color_idx + 3'd1;
      block_color <= color_lut(color_idx + 3'd1);
    end
  end
`else
  assign block_color = BLOCK_COLOR;
`endif

endmodule

// File: tb/tb_block_move_ctrl.sv
// tb_block_move_ctrl: directed bench for block_move_ctrl using three instances
// (default, STEP=4, FRAME_DIV=3) with hand-computed expected values.
module tb_block_move_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n, rst_n;
  logic vs0, vs1, vs2;
  logic run0, run1, run2;

  logic [10:0] x0, y0, x1, y1, x2, y2;
  logic        upd0, upd1, upd2;
  logic        dx0, dy0, dx1, dy1, dx2, dy2;
  logic [7:0]  b0, b1, b2;
  logic [23:0] c0, c1, c2;

  block_move_ctrl dut0 (
    .pixel_clk(clk), .sys_rst_n(rst0_n), .video_vs(vs0), .run(run0),
    .block_x(x0), .block_y(y0), .block_upd(upd0), .dir_x(dx0), .dir_y(dy0),
    .bounce_cnt(b0), .block_color(c0)
  );

  block_move_ctrl #(.STEP(4)) dut1 (
    .pixel_clk(clk), .sys_rst_n(rst_n), .video_vs(vs1), .run(run1),
    .block_x(x1), .block_y(y1), .block_upd(upd1), .dir_x(dx1), .dir_y(dy1),
    .bounce_cnt(b1), .block_color(c1)
  );

  block_move_ctrl #(.FRAME_DIV(3)) dut2 (
    .pixel_clk(clk), .sys_rst_n(rst_n), .video_vs(vs2), .run(run2),
    .block_x(x2), .block_y(y2), .block_upd(upd2), .dir_x(dx2), .dir_y(dy2),
    .bounce_cnt(b2), .block_color(c2)
  );

  typedef struct {
    int          frame;
    logic [10:0] x;
    logic [10:0] y;
    logic        dx;
    logic        dy;
    logic [7:0]  b;
  } vec_t;

  vec_t tbl [11];

  int n_checks = 0;
  int n_pass   = 0;
  int mon_err  = 0;
  int mon_changes = 0;
  logic [10:0] px, py;
  logic        pdx, pdy;
  logic        mon_valid = 1'b0;

  // Watch dut1 every cycle: position changes only with block_upd, always in range
  always @(negedge clk) begin
    if (rst_n && mon_valid) begin
      if ((x1 != px || y1 != py || dx1 != pdx || dy1 != pdy) && !upd1) mon_err++;
      if (x1 != px) mon_changes++;
      if (x1 > 11'd1240 || y1 > 11'd680) mon_err++;
    end
    px = x1; py = y1; pdx = dx1; pdy = dy1;
    mon_valid = rst_n;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [23:0] exp_color(input logic [7:0] b);
`ifdef BLOCK_COLOR_CYCLE_EN
    case (b[2:0])
      3'd0:    return 24'hFF0000;
      3'd1:    return 24'h00FF00;
      3'd2:    return 24'h0000FF;
      3'd3:    return 24'hFFFF00;
      3'd4:    return 24'h00FFFF;
      3'd5:    return 24'hFF00FF;
      3'd6:    return 24'hFFFFFF;
      default: return 24'h808080;
    endcase
`else
    return (b == b) ? 24'h0000FF : 24'h0;
`endif
  endfunction

  task automatic set_vs(input int which, input logic v);
    case (which)
      0:       vs0 = v;
      1:       vs1 = v;
      default: vs2 = v;
    endcase
  endtask

  function automatic logic get_upd(input int which);
    case (which)
      0:       return upd0;
      1:       return upd1;
      default: return upd2;
    endcase
  endfunction

  // One frame: vs high for 2 cycles, low for 2; report the cycle where block_upd is seen
  task automatic apply_stimulus(input int which, output int upd_cyc);
    upd_cyc = 0;
    set_vs(which, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) set_vs(which, 1'b0);
      if (get_upd(which) && upd_cyc == 0) upd_cyc = i;
    end
  endtask

  initial begin
    int cyc;
    int ti;
    int miss1;

    tbl[0]  = '{1,    11'd4,    11'd4,   1'b1, 1'b1, 8'd0};
    tbl[1]  = '{170,  11'd680,  11'd680, 1'b1, 1'b0, 8'd1};
    tbl[2]  = '{171,  11'd684,  11'd676, 1'b1, 1'b0, 8'd1};
    tbl[3]  = '{309,  11'd1236, 11'd124, 1'b1, 1'b0, 8'd1};
    tbl[4]  = '{310,  11'd1240, 11'd120, 1'b0, 1'b0, 8'd2};
    tbl[5]  = '{311,  11'd1236, 11'd116, 1'b0, 1'b0, 8'd2};
    tbl[6]  = '{340,  11'd1120, 11'd0,   1'b0, 1'b1, 8'd3};
    tbl[7]  = '{620,  11'd0,    11'd240, 1'b1, 1'b0, 8'd5};
    tbl[8]  = '{5269, 11'd1236, 11'd676, 1'b1, 1'b1, 8'd46};
    tbl[9]  = '{5270, 11'd1240, 11'd680, 1'b0, 1'b0, 8'd47};
    tbl[10] = '{5271, 11'd1236, 11'd676, 1'b0, 1'b0, 8'd47};

    rst0_n = 1'b0; rst_n = 1'b0;
    vs0 = 1'b0; vs1 = 1'b0; vs2 = 1'b0;
    run0 = 1'b1; run1 = 1'b1; run2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_x",     32'(x0),   32'd0);
    check_output("rst_y",     32'(y0),   32'd0);
    check_output("rst_dir_x", 32'(dx0),  32'd1);
    check_output("rst_dir_y", 32'(dy0),  32'd1);
    check_output("rst_upd",   32'(upd0), 32'd0);
    check_output("rst_bounce",32'(b0),   32'd0);
    check_output("rst_color", 32'(c0),   32'(exp_color(8'd0)));

    rst0_n = 1'b1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset release: first frame is swallowed by IDLE, second moves by one step
    apply_stimulus(0, cyc);
    check_output("idle_no_upd", 32'(cyc), 32'd0);
    apply_stimulus(0, cyc);
    check_output("first_upd_latency", 32'(cyc), 32'd2);
    check_output("first_x",     32'(x0),  32'd1);
    check_output("first_y",     32'(y0),  32'd1);
    check_output("first_dir_x", 32'(dx0), 32'd1);
    check_output("first_dir_y", 32'(dy0), 32'd1);
    check_output("first_bounce",32'(b0),  32'd0);

    // Frame divider of 3 with a pause in the middle of a count
    apply_stimulus(2, cyc);
    check_output("div_idle", 32'(cyc), 32'd0);
    for (int f = 1; f <= 6; f++) begin
      apply_stimulus(2, cyc);
      check_output("div_pulse", 32'(cyc != 0), 32'((f % 3) == 0));
    end
    apply_stimulus(2, cyc);
    check_output("div_frame7", 32'(cyc), 32'd0);
    run2 = 1'b0;
    for (int f = 0; f < 4; f++) begin
      apply_stimulus(2, cyc);
      check_output("pause_no_upd", 32'(cyc), 32'd0);
    end
    run2 = 1'b1;
    apply_stimulus(2, cyc);
    check_output("resume_first", 32'(cyc), 32'd0);
    apply_stimulus(2, cyc);
    check_output("resume_pulse", 32'(cyc), 32'd2);
    check_output("div_x_after", 32'(x2), 32'd3);

    // Long STEP=4 run through edge bounces and the (1240,680) corner
    apply_stimulus(1, cyc);
    check_output("s4_idle", 32'(cyc), 32'd0);
    ti = 0;
    miss1 = 0;
    for (int k = 1; k <= 5271; k++) begin
      apply_stimulus(1, cyc);
      if (cyc != 2) miss1++;
      if (ti < 11 && tbl[ti].frame == k) begin
        check_output($sformatf("s4_x_f%0d", k),      32'(x1),  32'(tbl[ti].x));
        check_output($sformatf("s4_y_f%0d", k),      32'(y1),  32'(tbl[ti].y));
        check_output($sformatf("s4_dir_x_f%0d", k),  32'(dx1), 32'(tbl[ti].dx));
        check_output($sformatf("s4_dir_y_f%0d", k),  32'(dy1), 32'(tbl[ti].dy));
        check_output($sformatf("s4_bounce_f%0d", k), 32'(b1),  32'(tbl[ti].b));
        check_output($sformatf("s4_color_f%0d", k),  32'(c1),  32'(exp_color(tbl[ti].b)));
        ti++;
      end
    end
    check_output("s4_upd_every_frame", 32'(miss1), 32'd0);
    check_output("atomic_in_range",    32'(mon_err), 32'd0);
    check_output("s4_change_count",    32'(mon_changes), 32'd5271);

    // Reset asserted while dut0 is in CALC clears outputs immediately
    vs0 = 1'b1;
    @(posedge clk);
    #1;
    rst0_n = 1'b0;
    #1;
    check_output("midrst_x",     32'(x0),   32'd0);
    check_output("midrst_y",     32'(y0),   32'd0);
    check_output("midrst_upd",   32'(upd0), 32'd0);
    check_output("midrst_dir_x", 32'(dx0),  32'd1);
    vs0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst0_n = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(0, cyc);
    check_output("midrst_idle", 32'(cyc), 32'd0);
    apply_stimulus(0, cyc);
    check_output("midrst_next_upd", 32'(cyc), 32'd2);
    check_output("midrst_next_x", 32'(x0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/block_move_ctrl.md
Name: block_move_ctrl

Overview:
Frame-synchronous scheduler for the moving-block display path. It samples the frame sync from the video timing driver and advances the block position once every FRAME_DIV frames. It reverses direction at the active-area edges and publishes the new (x,y) as one atomic update. The pixel generator reads block_x/block_y to draw the block; this block owns all motion sequencing.

Parameters:
H_DISP, 1280, active pixels per line
V_DISP, 720, active lines per frame
BLOCK_SIZE, 40, block edge length in pixels
STEP, 1, pixels moved per update on each axis (1..BLOCK_SIZE)
FRAME_DIV, 1, frames per position update (>=1)
BLOCK_COLOR, 24'h0000FF, block RGB when colour cycling is compiled out

Ports:
pixel_clk  in  1  pixel clock; all logic on rising edge
sys_rst_n  in  1  asynchronous active-low reset
video_vs  in  1  frame sync from video driver, same clock domain; a frame event is a 0->1 transition
run  in  1  1 = motion enabled, 0 = paused
block_x  out  11  block left edge, 0..H_DISP-BLOCK_SIZE
block_y  out  11  block top edge, 0..V_DISP-BLOCK_SIZE
block_upd  out  1  one-cycle pulse in the cycle new block_x/block_y first appear
dir_x  out  1  1 = moving right, 0 = left
dir_y  out  1  1 = moving down, 0 = up
bounce_cnt  out  8  count of commits containing at least one direction flip, wraps 255->0
block_color  out  24  block RGB for the pixel generator

Behaviour:
- Reset (async, sys_rst_n=0): block_x=0, block_y=0, dir_x=1, dir_y=1, block_upd=0, bounce_cnt=0, frame divider=0, FSM=IDLE, vs edge register=0, block_color=BLOCK_COLOR (or table[0] with the option).
- XMAX=H_DISP-BLOCK_SIZE, YMAX=V_DISP-BLOCK_SIZE, computed on 11 bits; compare on 12 bits so x+STEP cannot overflow.
- Edge detect: vs_d registers video_vs. frame_evt = video_vs & ~vs_d.
- FSM states: IDLE, WAIT, CALC, COMMIT.
  - IDLE: go to WAIT on the first frame_evt. That event never moves the block. This aligns the FSM to a frame boundary after reset.
  - WAIT: on frame_evt with run=1, if div==FRAME_DIV-1 then div=0 and go to CALC; otherwise div+1 and stay. A frame_evt with run=0 is ignored and div holds.
  - CALC: compute nx/ny/ndir into internal registers. block_x/block_y do not change.
    - X axis, moving right: if x+STEP>=XMAX then nx=XMAX and flip dir_x to 0; otherwise nx=x+STEP.
    - X axis, moving left: if x<=STEP then nx=0 and flip to 1; otherwise nx=x-STEP.
    - Y axis: same rules using YMAX and dir_y.
  - COMMIT: load block_x, block_y, dir_x and dir_y together. Pulse block_upd=1. If any flip occurred, bounce_cnt+1 (a corner hit counts once). Return to WAIT.
- Latency: frame_evt true in cycle N puts the FSM in CALC at N+1. block_upd and the new outputs appear at N+2 (registered).
- A frame_evt arriving during CALC or COMMIT is dropped. Not reachable with legal video timing.
- Dropping run during CALC or COMMIT does not abort the update; that commit completes.
- Outputs change only in COMMIT or on reset. block_x/block_y never exceed XMAX/YMAX.
- Reset asserted mid-sequence returns everything to reset values immediately. The next frame_evt after release is consumed by IDLE.

Optional Feature:
BLOCK_COLOR_CYCLE_EN
- Defined: an internal 3-bit index steps on every commit where bounce_cnt increments, wrapping 7->0.
- block_color = table[index]. Table order: FF0000, 00FF00, 0000FF, FFFF00, 00FFFF, FF00FF, FFFFFF, 808080.
- block_color is registered and updates in the COMMIT cycle. Reset sets index=0.
- Undefined: block_color is constant BLOCK_COLOR, and no index register exists.

Test Plan:
- Reset/IDLE: release reset, then pulse video_vs twice with run=1 and default parameters -> first edge causes no block_upd; second edge gives block_upd exactly 2 cycles after vs rises, with x=1, y=1, dir_x=1, dir_y=1.
- Right-edge bounce, STEP=4: start from x=1236, dir_x=1 and apply 2 frames -> x=1240 with dir_x=0 and bounce_cnt=1, then x=1236.
- Corner: STEP=4 with x=1236, y=676, both dirs 1 -> commit gives x=1240, y=680, dir_x=0, dir_y=0 and bounce_cnt incremented by exactly 1. With BLOCK_COLOR_CYCLE_EN, block_color changes FF0000->00FF00.
- Pause/divider, FRAME_DIV=3: six frames with run=1 -> exactly 2 block_upd pulses, on frames 3 and 6 after IDLE. Hold run=0 for 4 frames -> no pulses and div unchanged. Resume -> the next pulse comes after the remaining frame count.
- Atomic update: monitor every cycle -> block_x/block_y change only in cycles where block_upd=1, and remain <=1240/<=680 over 2000 frames.
- Reset mid-op: assert sys_rst_n=0 in the CALC cycle -> outputs show reset values in the same cycle (async). After release, the first vs edge yields no update.
